cache_axi_bridge: RTL and testbench
===================================

Name: cache_axi_bridge

Overview:
Parametrised bridge between the I-cache/D-cache miss interfaces and a single AXI3 master port, generalising line size to LINE_WORDS words. Round-robin read arbitration with one outstanding read per cache. Single write channel that holds until the B response. Read-after-write hazard check that blocks a D-cache read to a line with an unfinished write.

Parameters:
LINE_WORDS, 4, words per cache line (2, 4, 8 or 16); burst len = LINE_WORDS-1
ID_W, 4, AXI ID width; inst reads use ID 0, data reads and all writes use ID 1
OFFS_W, $clog2(LINE_WORDS*4), byte-offset bits ignored by the hazard compare

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_rd_req / inst_rd_type / inst_rd_addr  in  1/1/32  I-cache read request; type 1 = line, 0 = single word
inst_rd_rdy  out  1  I-cache request accepted when req&rdy
inst_ret_valid / inst_ret_data  out  1/32*LINE_WORDS  one-cycle return pulse and line data, word 0 in LSBs
data_rd_req / data_rd_type / data_rd_addr / data_rd_size  in  1/1/32/3  D-cache read request
data_rd_rdy  out  1  D-cache read accepted
data_ret_valid / data_ret_data  out  1/32*LINE_WORDS  D-cache return
data_wr_req / data_wr_type / data_wr_addr / data_wr_size / data_wr_wstrb / data_wr_data  in  1/1/32/3/4/32*LINE_WORDS  D-cache write request
data_wr_rdy  out  1  write accepted
data_wr_ok  out  1  one-cycle pulse after B handshake
bus_err  out  1  one-cycle pulse on a nonzero rresp (with rlast) or a nonzero bresp
axi_ar*, axi_r*, axi_aw*, axi_w*, axi_b*  AXI3 master  standard widths; IDs are ID_W bits wide

Behaviour:
- Reset: all valid, ready-to-cache and pulse outputs 0; axi_rready=1 constant; axi_bready=0; internal state IDLE; outstanding flags and last-grant reset to 0 (inst).
- Constant AXI fields: arburst/awburst=01, lock=0, cache=0, prot=0.
- AR FSM, AR_IDLE -> AR_SEND:
  - In AR_IDLE a port is eligible if req=1, its outstanding flag is clear and, for data only, there is no hazard.
  - If both ports are eligible, grant the port not granted last; otherwise grant the eligible one. rd_rdy=1 only for the granted port.
  - On grant, register arid, araddr, arlen (type ? LINE_WORDS-1 : 0) and arsize (line: 2; single: inst 2, data data_rd_size); set the outstanding flag.
  - In AR_SEND, arvalid=1 with stable fields until arready, then return to AR_IDLE. arvalid asserts the cycle after grant.
- R path:
  - Per-ID beat counter (log2 LINE_WORDS bits) selects the word slot in that ID's line buffer; rid[0] selects the buffer.
  - On the rlast beat: clear that ID's counter and outstanding flag, and pulse ret_valid in the next cycle with the full buffer.
  - Interleaved inst and data beats are both supported.
  - A single-word read places its word in slot 0.
- Hazard: data_rd blocked while the W FSM is not W_IDLE and data_rd_addr[31:OFFS_W] == awaddr[31:OFFS_W].
- W FSM, W_IDLE -> W_AW -> W_DATA -> W_B -> W_IDLE:
  - data_wr_rdy = (W_IDLE). On acceptance, latch addr, data, awlen (type ? LINE_WORDS-1 : 0), awsize (type ? 2 : size) and wstrb (type ? 1111 : data_wr_wstrb).
  - W_AW: awvalid until awready.
  - W_DATA: wvalid=1, wdata = word[wcount], wlast when wcount==awlen, wcount increments per handshake.
  - W_B: bready=1; on bvalid, pulse data_wr_ok in the next cycle and return to W_IDLE. Exactly one write is in flight at a time.
- Simultaneous events:
  - The data read and write paths are independent, so a read and a write may both be accepted in the same cycle unless the hazard blocks the read.
  - rlast and a new grant for the same port in the same cycle: no grant, because the flag is still set; the grant can happen the next cycle.
- Reset mid-operation drops all transactions and buffers. The system must reset the interconnect together with this block.
- The ret_data buffer holds its value until that ID's next beat.

Test Plan:
- I-cache line read at 0x1FC0_0000, LINE_WORDS=4: arlen=3, arsize=2, arid=0. Return beats A0..A3 -> inst_ret_valid for 1 cycle after rlast, inst_ret_data={A3,A2,A1,A0}.
- inst and data requests in the same idle cycle, twice in a row: grants alternate (data, inst, data...). data beats interleaved with inst beats -> both lines assemble correctly.
- Dirty line write at 0x8000_0040 followed by a data read of 0x8000_0048: data_rd_rdy=0 until data_wr_ok. Read of 0x8000_0080 during the same write is accepted immediately.
- Uncached store: size=0, wstrb=0100, type=0 -> awlen=0, awsize=0, wstrb=0100, wlast on the first beat, data_wr_ok one cycle after bvalid.
- bresp=10 on a write -> bus_err pulses one cycle and data_wr_ok still pulses. rresp=10 on rlast -> bus_err and ret_valid both pulse.
- LINE_WORDS=8 build: 8-beat write, wlast only on beat 7. Slave withholds arready for 5 cycles -> araddr held stable, no second grant for that port.

Source files
------------

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if: AXI3 channel bundle between the cache bridge and the interconnect
interface cache_axi_bridge_if #(parameter int ID_W = 4);
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic [3:0]      arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]      arsize, awsize, arprot, awprot;
    logic [1:0]      arburst, awburst, arlock, awlock, rresp, bresp;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: I/D-cache miss ports onto one AXI3 master with round-robin reads and RAW hazard blocking
module cache_axi_bridge #(
    parameter int LINE_WORDS = 4,
    parameter int ID_W       = 4,
    parameter int OFFS_W     = $clog2(LINE_WORDS*4)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    inst_rd_req_i,
    input  logic                    inst_rd_type_i,
    input  logic [31:0]             inst_rd_addr_i,
    output logic                    inst_rd_rdy_o,
    output logic                    inst_ret_valid_o,
    output logic [32*LINE_WORDS-1:0] inst_ret_data_o,
    input  logic                    data_rd_req_i,
    input  logic                    data_rd_type_i,
    input  logic [31:0]             data_rd_addr_i,
    input  logic [2:0]              data_rd_size_i,
    output logic                    data_rd_rdy_o,
    output logic                    data_ret_valid_o,
    output logic [32*LINE_WORDS-1:0] data_ret_data_o,
    input  logic                    data_wr_req_i,
    input  logic                    data_wr_type_i,
    input  logic [31:0]             data_wr_addr_i,
    input  logic [2:0]              data_wr_size_i,
    input  logic [3:0]              data_wr_wstrb_i,
    input  logic [32*LINE_WORDS-1:0] data_wr_data_i,
    output logic                    data_wr_rdy_o,
    output logic                    data_wr_ok_o,
    output logic                    bus_err_o,
    cache_axi_bridge_if.master      axi
);
    localparam int CW = $clog2(LINE_WORDS);
    localparam int LW = 32*LINE_WORDS;
    localparam logic [3:0] LEN = 4'(LINE_WORDS-1);

    typedef enum logic {AR_IDLE, AR_SEND} ar_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_t;

    ar_t             ar_q;
    w_t              w_q;
    logic [1:0]      out_q, ret_q;
    logic            last_q, wr_ok_q, err_q;
    logic [CW-1:0]   cnt_q [2];
    logic [LW-1:0]   buf_q [2];
    logic [ID_W-1:0] arid_q;
    logic [31:0]     araddr_q, awaddr_q;
    logic [3:0]      arlen_q, awlen_q, wstrb_q;
    logic [2:0]      arsize_q, awsize_q;
    logic [LW-1:0]   wbuf_q;
    logic [CW-1:0]   wcnt_q;
    logic            hazard, inst_el, data_el, gnt_i, gnt_d, rb, wlast, b_hs, unused_ok;

    // arbitration: data wins a tie only when inst was granted last (last_q=1 means data went last)
    always_comb begin
        hazard  = w_q != W_IDLE && data_rd_addr_i[31:OFFS_W] == awaddr_q[31:OFFS_W];
        inst_el = resetn && ar_q == AR_IDLE && inst_rd_req_i && !out_q[0];
        data_el = resetn && ar_q == AR_IDLE && data_rd_req_i && !out_q[1] && !hazard;
        gnt_d   = data_el && (!inst_el || !last_q);
        gnt_i   = inst_el && !gnt_d;
        rb      = axi.rid[0];
        wlast   = wcnt_q == awlen_q[CW-1:0];
        b_hs    = axi.bvalid && w_q == W_B;
    end

    assign unused_ok        = &{1'b0, axi.bid, axi.rid};
    assign inst_rd_rdy_o    = gnt_i;
    assign data_rd_rdy_o    = gnt_d;
    assign data_wr_rdy_o    = resetn && w_q == W_IDLE;
    assign inst_ret_valid_o = ret_q[0];
    assign data_ret_valid_o = ret_q[1];
    assign inst_ret_data_o  = buf_q[0];
    assign data_ret_data_o  = buf_q[1];
    assign data_wr_ok_o     = wr_ok_q;
    assign bus_err_o        = err_q;
    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = ar_q == AR_SEND;
    assign axi.rready  = 1'b1;
    assign axi.awid    = ID_W'(1);
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = w_q == W_AW;
    assign axi.wid     = ID_W'(1);
    assign axi.wdata   = wbuf_q[32*wcnt_q +: 32];
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wlast;
    assign axi.wvalid  = w_q == W_DATA;
    assign axi.bready  = w_q == W_B;

    // AR channel: latch the granted request and hold arvalid with stable fields until arready
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_q     <= AR_IDLE;
            last_q   <= 1'b0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else if (gnt_i || gnt_d) begin
            ar_q     <= AR_SEND;
            last_q   <= gnt_d;
            arid_q   <= ID_W'(gnt_d);
            araddr_q <= gnt_d ? data_rd_addr_i : inst_rd_addr_i;
            arlen_q  <= (gnt_d ? data_rd_type_i : inst_rd_type_i) ? LEN : 4'd0;
            arsize_q <= (gnt_d && !data_rd_type_i) ? data_rd_size_i : 3'd2;
        end else if (ar_q == AR_SEND && axi.arready) begin
            ar_q <= AR_IDLE;
        end
    end

    // R path: per-ID beat slotting, outstanding flags, return and error pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q <= '0;
            ret_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '{default: '0};
            buf_q <= '{default: '0};
        end else begin
            ret_q <= '0;
            err_q <= (axi.rvalid && axi.rlast && |axi.rresp) || (b_hs && |axi.bresp);
            if (gnt_i) out_q[0] <= 1'b1;
            if (gnt_d) out_q[1] <= 1'b1;
            if (axi.rvalid) begin
                buf_q[rb][32*cnt_q[rb] +: 32] <= axi.rdata;
                cnt_q[rb] <= axi.rlast ? '0 : cnt_q[rb] + 1'b1;
                if (axi.rlast) begin
                    out_q[rb] <= 1'b0;
                    ret_q[rb] <= 1'b1;
                end
            end
        end
    end

    // W channel: single write in flight, address then data beats then B response
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_q      <= W_IDLE;
            awaddr_q <= '0;
            awlen_q  <= '0;
            awsize_q <= '0;
            wstrb_q  <= '0;
            wbuf_q   <= '0;
            wcnt_q   <= '0;
            wr_ok_q  <= 1'b0;
        end else begin
            wr_ok_q <= b_hs;
            case (w_q)
                W_IDLE: if (data_wr_req_i) begin
                    w_q      <= W_AW;
                    awaddr_q <= data_wr_addr_i;
                    awlen_q  <= data_wr_type_i ? LEN : 4'd0;
                    awsize_q <= data_wr_type_i ? 3'd2 : data_wr_size_i;
                    wstrb_q  <= data_wr_type_i ? 4'b1111 : data_wr_wstrb_i;
                    wbuf_q   <= data_wr_data_i;
                end
                W_AW:   if (axi.awready) w_q <= W_DATA;
                W_DATA: if (axi.wready) begin
                    wcnt_q <= wlast ? '0 : wcnt_q + 1'b1;
                    if (wlast) w_q <= W_B;
                end
                W_B:    if (axi.bvalid) w_q <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: directed bench with a return-data scoreboard for the cache AXI bridge
module tb_cache_axi_bridge;
    logic clk = 0, resetn = 0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic         inst_rd_req = 0, inst_rd_type = 0, data_rd_req = 0, data_rd_type = 0;
    logic [31:0]  inst_rd_addr = 0, data_rd_addr = 0, data_wr_addr = 0;
    logic [2:0]   data_rd_size = 0, data_wr_size = 0;
    logic         data_wr_req = 0, data_wr_type = 0;
    logic [3:0]   data_wr_wstrb = 0;
    logic [127:0] data_wr_data = 0;
    logic         inst_rd_rdy, inst_ret_valid, data_rd_rdy, data_ret_valid, data_wr_rdy, data_wr_ok, bus_err;
    logic [127:0] inst_ret_data, data_ret_data;

    logic         w8_req = 0;
    logic [255:0] w8_data = 0;
    logic         i8_rdy, i8_rv, d8_rdy, d8_rv, w8_rdy, w8_ok, err8;
    logic [255:0] i8_rd, d8_rd;

    cache_axi_bridge_if #(.ID_W(4)) a();
    cache_axi_bridge_if #(.ID_W(4)) b8();

    cache_axi_bridge #(.LINE_WORDS(4), .ID_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_rd_req_i(inst_rd_req), .inst_rd_type_i(inst_rd_type), .inst_rd_addr_i(inst_rd_addr),
        .inst_rd_rdy_o(inst_rd_rdy), .inst_ret_valid_o(inst_ret_valid), .inst_ret_data_o(inst_ret_data),
        .data_rd_req_i(data_rd_req), .data_rd_type_i(data_rd_type), .data_rd_addr_i(data_rd_addr),
        .data_rd_size_i(data_rd_size), .data_rd_rdy_o(data_rd_rdy), .data_ret_valid_o(data_ret_valid),
        .data_ret_data_o(data_ret_data), .data_wr_req_i(data_wr_req), .data_wr_type_i(data_wr_type),
        .data_wr_addr_i(data_wr_addr), .data_wr_size_i(data_wr_size), .data_wr_wstrb_i(data_wr_wstrb),
        .data_wr_data_i(data_wr_data), .data_wr_rdy_o(data_wr_rdy), .data_wr_ok_o(data_wr_ok),
        .bus_err_o(bus_err), .axi(a)
    );

    cache_axi_bridge #(.LINE_WORDS(8), .ID_W(4)) dut8 (
        .clk(clk), .resetn(resetn),
        .inst_rd_req_i(1'b0), .inst_rd_type_i(1'b0), .inst_rd_addr_i(32'h0),
        .inst_rd_rdy_o(i8_rdy), .inst_ret_valid_o(i8_rv), .inst_ret_data_o(i8_rd),
        .data_rd_req_i(1'b0), .data_rd_type_i(1'b0), .data_rd_addr_i(32'h0),
        .data_rd_size_i(3'd0), .data_rd_rdy_o(d8_rdy), .data_ret_valid_o(d8_rv),
        .data_ret_data_o(d8_rd), .data_wr_req_i(w8_req), .data_wr_type_i(1'b1),
        .data_wr_addr_i(32'h4000_0000), .data_wr_size_i(3'd2), .data_wr_wstrb_i(4'h0),
        .data_wr_data_i(w8_data), .data_wr_rdy_o(w8_rdy), .data_wr_ok_o(w8_ok),
        .bus_err_o(err8), .axi(b8)
    );

    logic [127:0] iq[$], dq[$];
    logic [127:0] iexp, dexp, wline;
    logic         haz_watch = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ar_accept(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size);
        @(negedge clk);
        chk(tag, {a.arvalid, a.arid, a.araddr, a.arlen, a.arsize}, {1'b1, id, addr, len, size});
        a.arready = 1;
        step;
        a.arready = 0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic last, input logic [1:0] resp);
        a.rvalid = 1; a.rid = id; a.rdata = data; a.rlast = last; a.rresp = resp;
        step;
        a.rvalid = 0; a.rlast = 0; a.rresp = 0;
    endtask

    task automatic w_slave(input string tag, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [3:0] strb, input logic [127:0] line, input logic [1:0] resp);
        @(negedge clk);
        chk({tag, "_aw"}, {a.awvalid, a.awid, a.awaddr, a.awlen, a.awsize}, {1'b1, 4'd1, addr, len, size});
        a.awready = 1;
        step;
        a.awready = 0;
        for (int k = 0; k <= int'(len); k++) begin
            @(negedge clk);
            chk({tag, "_w"}, {a.wvalid, a.wid, a.wdata, a.wstrb, a.wlast}, {1'b1, 4'd1, line[32*k +: 32], strb, k == int'(len)});
            a.wready = 1;
            step;
            a.wready = 0;
        end
        @(negedge clk);
        chk({tag, "_bready"}, a.bready, 1);
        a.bvalid = 1; a.bresp = resp;
        step;
        a.bvalid = 0; a.bresp = 0;
    endtask

    task automatic wr_done(input string tag, input logic err);
        @(negedge clk);
        chk(tag, {data_wr_ok, bus_err, data_wr_rdy}, {1'b1, err, 1'b1});
        step;
        @(negedge clk);
        chk({tag, "_pulse"}, {data_wr_ok, bus_err}, 2'b00);
        step;
    endtask

    // scoreboard: each return pulse must match the oldest expected line for that port
    always @(negedge clk) begin
        if (inst_ret_valid) begin
            if (iq.size() == 0) chk("inst_ret_extra", inst_ret_valid, 0);
            else chk("inst_ret_data", inst_ret_data, iq.pop_front());
        end
        if (data_ret_valid) begin
            if (dq.size() == 0) chk("data_ret_extra", data_ret_valid, 0);
            else chk("data_ret_data", data_ret_data, dq.pop_front());
        end
        if (haz_watch) chk("haz_hold", data_rd_rdy, 0);
    end

    initial begin
        a.arready = 0; a.rvalid = 0; a.rid = 0; a.rdata = 0; a.rresp = 0; a.rlast = 0;
        a.awready = 0; a.wready = 0; a.bvalid = 0; a.bid = 0; a.bresp = 0;
        b8.arready = 0; b8.rvalid = 0; b8.rid = 0; b8.rdata = 0; b8.rresp = 0; b8.rlast = 0;
        b8.awready = 0; b8.wready = 0; b8.bvalid = 0; b8.bid = 0; b8.bresp = 0;
        inst_rd_req = 1; inst_rd_type = 1; inst_rd_addr = 32'h1FC0_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {inst_rd_rdy, data_rd_rdy, data_wr_rdy, inst_ret_valid, data_ret_valid, data_wr_ok,
                           bus_err, a.arvalid, a.awvalid, a.wvalid, a.bready, a.rready}, 12'b0000_0000_0001);
        step;
        resetn = 1;
        @(negedge clk);
        chk("const_fields", {a.arburst, a.awburst, a.arlock, a.awlock, a.arcache, a.awcache, a.arprot, a.awprot},
            {2'b01, 2'b01, 18'd0});
        chk("inst_grant", {inst_rd_rdy, data_rd_rdy}, 2'b10);
        step;
        inst_rd_req = 0;
        ar_accept("ar_inst_line", 4'd0, 32'h1FC0_0000, 4'd3, 3'd2);
        for (int k = 0; k < 4; k++) iexp[32*k +: 32] = 32'hA000_0000 + k;
        iq.push_back(iexp);
        for (int k = 0; k < 4; k++) r_beat(4'd0, 32'hA000_0000 + k, k == 3, 2'b00);
        @(negedge clk);
        chk("inst_ret_pulse", inst_ret_valid, 1);
        step;

        inst_rd_req = 1; inst_rd_type = 1; inst_rd_addr = 32'h1100_0000;
        data_rd_req = 1; data_rd_type = 1; data_rd_addr = 32'h2100_0000; data_rd_size = 3'd2;
        @(negedge clk);
        chk("rr_first_data", {inst_rd_rdy, data_rd_rdy}, 2'b01);
        step;
        data_rd_req = 0;
        ar_accept("ar_data_line", 4'd1, 32'h2100_0000, 4'd3, 3'd2);
        @(negedge clk);
        chk("rr_then_inst", {inst_rd_rdy, data_rd_rdy}, 2'b10);
        step;
        inst_rd_req = 0;
        ar_accept("ar_inst_line2", 4'd0, 32'h1100_0000, 4'd3, 3'd2);
        for (int k = 0; k < 4; k++) begin
            dexp[32*k +: 32] = 32'hD100_0000 + k;
            iexp[32*k +: 32] = 32'hB100_0000 + k;
        end
        dq.push_back(dexp);
        iq.push_back(iexp);
        for (int k = 0; k < 4; k++) begin
            r_beat(4'd1, 32'hD100_0000 + k, k == 3, 2'b00);
            r_beat(4'd0, 32'hB100_0000 + k, k == 3, 2'b00);
        end

        inst_rd_req = 1; inst_rd_type = 0; inst_rd_addr = 32'h1000_0004;
        data_rd_req = 1; data_rd_type = 0; data_rd_addr = 32'h2000_0002; data_rd_size = 3'd1;
        @(negedge clk);
        chk("rr_data_again", {inst_rd_rdy, data_rd_rdy}, 2'b01);
        step;
        data_rd_req = 0;
        ar_accept("ar_data_word", 4'd1, 32'h2000_0002, 4'd0, 3'd1);
        @(negedge clk);
        chk("rr_inst_again", {inst_rd_rdy, data_rd_rdy}, 2'b10);
        step;
        inst_rd_type = 1; inst_rd_addr = 32'h1000_0100;
        ar_accept("ar_inst_word", 4'd0, 32'h1000_0004, 4'd0, 3'd2);
        @(negedge clk);
        chk("inst_outstanding", inst_rd_rdy, 0);
        step;
        dexp[31:0] = 32'hD200_0000;
        dq.push_back(dexp);
        r_beat(4'd1, 32'hD200_0000, 1'b1, 2'b00);
        iexp[31:0] = 32'hB200_0000;
        iq.push_back(iexp);
        a.rvalid = 1; a.rid = 0; a.rdata = 32'hB200_0000; a.rlast = 1;
        @(negedge clk);
        chk("rlast_no_grant", inst_rd_rdy, 0);
        step;
        a.rvalid = 0; a.rlast = 0;
        @(negedge clk);
        chk("regrant_after_rlast", {inst_rd_rdy, inst_ret_valid}, 2'b11);
        step;
        inst_rd_addr = 32'h1000_0200;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("ar_hold", {a.arvalid, a.araddr, inst_rd_rdy}, {1'b1, 32'h1000_0100, 1'b0});
            step;
        end
        inst_rd_req = 0;
        ar_accept("ar_inst_held", 4'd0, 32'h1000_0100, 4'd3, 3'd2);
        for (int k = 0; k < 4; k++) iexp[32*k +: 32] = 32'hE000_0000 + k;
        iq.push_back(iexp);
        for (int k = 0; k < 4; k++) r_beat(4'd0, 32'hE000_0000 + k, k == 3, k == 3 ? 2'b10 : 2'b00);
        @(negedge clk);
        chk("rresp_err", {inst_ret_valid, bus_err}, 2'b11);
        step;

        for (int k = 0; k < 4; k++) wline[32*k +: 32] = 32'h5000_0000 + k;
        data_wr_req = 1; data_wr_type = 1; data_wr_addr = 32'h8000_0040; data_wr_size = 3'd2;
        data_wr_wstrb = 4'h0; data_wr_data = wline;
        @(negedge clk);
        chk("wr_accept", data_wr_rdy, 1);
        step;
        data_wr_req = 0;
        data_rd_req = 1; data_rd_type = 0; data_rd_size = 3'd2; data_rd_addr = 32'h8000_0048;
        @(negedge clk);
        chk("haz_block", data_rd_rdy, 0);
        step;
        data_rd_addr = 32'h8000_0080;
        @(negedge clk);
        chk("haz_other_line", data_rd_rdy, 1);
        step;
        data_rd_req = 0;
        ar_accept("ar_other_line", 4'd1, 32'h8000_0080, 4'd0, 3'd2);
        dexp[31:0] = 32'hD300_0000;
        dq.push_back(dexp);
        r_beat(4'd1, 32'hD300_0000, 1'b1, 2'b00);
        data_rd_req = 1; data_rd_addr = 32'h8000_0048;
        haz_watch = 1;
        w_slave("wr_line", 32'h8000_0040, 4'd3, 3'd2, 4'hF, wline, 2'b00);
        haz_watch = 0;
        @(negedge clk);
        chk("haz_release", {data_wr_ok, data_rd_rdy, bus_err}, 3'b110);
        step;
        data_rd_req = 0;
        ar_accept("ar_after_write", 4'd1, 32'h8000_0048, 4'd0, 3'd2);
        dexp[31:0] = 32'hD400_0000;
        dq.push_back(dexp);
        r_beat(4'd1, 32'hD400_0000, 1'b1, 2'b00);

        wline = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'h00AB_0000};
        data_wr_req = 1; data_wr_type = 0; data_wr_addr = 32'h9000_0002; data_wr_size = 3'd0;
        data_wr_wstrb = 4'b0100; data_wr_data = wline;
        step;
        data_wr_req = 0;
        w_slave("wr_store", 32'h9000_0002, 4'd0, 3'd0, 4'b0100, wline, 2'b00);
        wr_done("store_ok", 1'b0);

        for (int k = 0; k < 4; k++) wline[32*k +: 32] = 32'h6000_0000 + k;
        data_wr_req = 1; data_wr_type = 1; data_wr_addr = 32'hA000_0000; data_wr_size = 3'd2;
        data_wr_wstrb = 4'h0; data_wr_data = wline;
        step;
        data_wr_req = 0;
        w_slave("wr_err", 32'hA000_0000, 4'd3, 3'd2, 4'hF, wline, 2'b10);
        wr_done("bresp_err", 1'b1);

        for (int k = 0; k < 8; k++) w8_data[32*k +: 32] = 32'hC0DE_0000 + k;
        w8_req = 1;
        @(negedge clk);
        chk("w8_accept", w8_rdy, 1);
        step;
        w8_req = 0;
        @(negedge clk);
        chk("w8_aw", {b8.awvalid, b8.awaddr, b8.awlen, b8.awsize}, {1'b1, 32'h4000_0000, 4'd7, 3'd2});
        b8.awready = 1;
        step;
        b8.awready = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("w8_beat", {b8.wvalid, b8.wdata, b8.wstrb, b8.wlast}, {1'b1, 32'hC0DE_0000 + k, 4'hF, k == 7});
            b8.wready = 1;
            step;
            b8.wready = 0;
        end
        b8.bvalid = 1;
        step;
        b8.bvalid = 0;
        @(negedge clk);
        chk("w8_ok", {w8_ok, err8}, 2'b10);
        step;
        repeat (3) step;
        chk("inst_sb_drained", iq.size(), 0);
        chk("data_sb_drained", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
